// File: rtl/multicycle_control_pkg.sv
// Shared datapath types: mux select encodings plus the rv32i opcode, operation and state constants.
// Pure type and constant definitions; no logic, no latency, no flow control.
package pcmux;
   typedef enum logic [1:0] {
      pc_plus4 = 2'b00,
      alu_out  = 2'b01,
      alu_mod2 = 2'b10
   } pcmux_sel_t;
endpackage

package alumux;
   typedef enum logic {
      rs1_out = 1'b0,
      pc_out  = 1'b1
   } alumux1_sel_t;

   typedef enum logic [2:0] {
      i_imm   = 3'b000,
      u_imm   = 3'b001,
      b_imm   = 3'b010,
      s_imm   = 3'b011,
      j_imm   = 3'b100,
      rs2_out = 3'b101
   } alumux2_sel_t;
endpackage

package regfilemux;
   typedef enum logic [3:0] {
      alu_out  = 4'd0,
      br_en    = 4'd1,
      u_imm    = 4'd2,
      lw       = 4'd3,
      pc_plus4 = 4'd4,
      lb       = 4'd5,
      lbu      = 4'd6,
      lh       = 4'd7,
      lhu      = 4'd8
   } regfilemux_sel_t;
endpackage

package cmpmux;
   typedef enum logic {
      rs2_out = 1'b0,
      i_imm   = 1'b1
   } cmpmux_sel_t;
endpackage

package rv32i_types;
   localparam logic [6:0] op_lui   = 7'b0110111;
   localparam logic [6:0] op_auipc = 7'b0010111;
   localparam logic [6:0] op_jal   = 7'b1101111;
   localparam logic [6:0] op_jalr  = 7'b1100111;
   localparam logic [6:0] op_br    = 7'b1100011;
   localparam logic [6:0] op_load  = 7'b0000011;
   localparam logic [6:0] op_store = 7'b0100011;
   localparam logic [6:0] op_imm   = 7'b0010011;
   localparam logic [6:0] op_reg   = 7'b0110011;

   // ALU codes reuse funct3 directly; the SLT/SLTU slots carry SRA/SUB since compares go to the comparator
   typedef enum logic [2:0] {
      alu_add = 3'b000,
      alu_sll = 3'b001,
      alu_sra = 3'b010,
      alu_sub = 3'b011,
      alu_xor = 3'b100,
      alu_srl = 3'b101,
      alu_or  = 3'b110,
      alu_and = 3'b111
   } alu_ops;

   typedef enum logic [2:0] {
      beq  = 3'b000,
      bne  = 3'b001,
      blt  = 3'b100,
      bge  = 3'b101,
      bltu = 3'b110,
      bgeu = 3'b111
   } branch_funct3_t;

   localparam logic [2:0] f3_add  = 3'b000;
   localparam logic [2:0] f3_slt  = 3'b010;
   localparam logic [2:0] f3_sltu = 3'b011;
   localparam logic [2:0] f3_sr   = 3'b101;
   localparam logic [2:0] f3_lb   = 3'b000;
   localparam logic [2:0] f3_lh   = 3'b001;
   localparam logic [2:0] f3_lw   = 3'b010;
   localparam logic [2:0] f3_lbu  = 3'b100;
   localparam logic [2:0] f3_lhu  = 3'b101;
   localparam logic [2:0] f3_sb   = 3'b000;
   localparam logic [2:0] f3_sh   = 3'b001;
   localparam logic [2:0] f3_sw   = 3'b010;

   typedef logic [3:0] state_t;
   localparam state_t s_fetch1    = 4'd0;
   localparam state_t s_fetch2    = 4'd1;
   localparam state_t s_fetch3    = 4'd2;
   localparam state_t s_decode    = 4'd3;
   localparam state_t s_imm       = 4'd4;
   localparam state_t s_reg       = 4'd5;
   localparam state_t s_lui       = 4'd6;
   localparam state_t s_auipc     = 4'd7;
   localparam state_t s_br        = 4'd8;
   localparam state_t s_jal       = 4'd9;
   localparam state_t s_jalr      = 4'd10;
   localparam state_t s_calc_addr = 4'd11;
   localparam state_t s_ld1       = 4'd12;
   localparam state_t s_ld2       = 4'd13;
   localparam state_t s_st1       = 4'd14;
   localparam state_t s_st2       = 4'd15;

   function automatic logic known_opcode(input logic [6:0] op);
      case (op)
         op_lui, op_auipc, op_jal, op_jalr, op_br,
         op_load, op_store, op_imm, op_reg: return 1'b1;
         default:                          return 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] off);
      case (f3)
         f3_sb:   return 4'b0001 << off;
         f3_sh:   return 4'b0011 << off;
         f3_sw:   return 4'b1111;
         default: return 4'b1111;
      endcase
   endfunction
endpackage

// File: rtl/multicycle_control.sv
// Multicycle rv32i control FSM; outputs are combinational from state and inputs (zero latency).
// Memory strobes hold until mem_resp; the FSM stalls in FETCH2/LD1/ST1 until the response pulse.
module multicycle_control
   import rv32i_types::*;
(
   input  logic                        clk,
   input  logic                        rst,
   input  logic [6:0]                  opcode,
   input  logic [2:0]                  funct3,
   input  logic                        funct7,
   input  logic                        br_en,
   input  logic [1:0]                  addr_lo,
   input  logic                        mem_resp,
   output logic                        load_pc,
   output logic                        load_ir,
   output logic                        load_regfile,
   output logic                        load_mar,
   output logic                        load_mdr,
   output logic                        load_data_out,
   output pcmux::pcmux_sel_t           pcmux_sel,
   output alumux::alumux1_sel_t        alumux1_sel,
   output alumux::alumux2_sel_t        alumux2_sel,
   output regfilemux::regfilemux_sel_t regfilemux_sel,
   output cmpmux::cmpmux_sel_t         cmpmux_sel,
   output logic                        marmux_sel,
   output alu_ops                      aluop,
   output branch_funct3_t              cmpop,
   output logic                        mem_read,
   output logic                        mem_write,
   output logic [3:0]                  mem_byte_enable
);

   state_t state;
   state_t next_state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= s_fetch1;
      else     state <= next_state;
   end

   always_comb begin
      load_pc         = 1'b0;
      load_ir         = 1'b0;
      load_regfile    = 1'b0;
      load_mar        = 1'b0;
      load_mdr        = 1'b0;
      load_data_out   = 1'b0;
      pcmux_sel       = pcmux::pc_plus4;
      alumux1_sel     = alumux::rs1_out;
      alumux2_sel     = alumux::i_imm;
      regfilemux_sel  = regfilemux::alu_out;
      cmpmux_sel      = cmpmux::rs2_out;
      marmux_sel      = 1'b0;
      aluop           = alu_add;
      cmpop           = beq;
      mem_read        = 1'b0;
      mem_write       = 1'b0;
      mem_byte_enable = 4'b1111;
      case (state)
         s_fetch1: load_mar = 1'b1;
         s_fetch2: begin
            mem_read = 1'b1;
            load_mdr = 1'b1;
         end
         s_fetch3: load_ir = 1'b1;
         // An unknown opcode is skipped by simply stepping the PC
         s_decode: load_pc = !known_opcode(opcode);
         s_imm: begin
            load_regfile = 1'b1;
            load_pc      = 1'b1;
            aluop        = alu_ops'(funct3);
            if (funct3 == f3_slt || funct3 == f3_sltu) begin
               cmpop          = (funct3 == f3_slt) ? blt : bltu;
               cmpmux_sel     = cmpmux::i_imm;
               regfilemux_sel = regfilemux::br_en;
            end else if (funct3 == f3_sr && funct7) begin
               aluop = alu_sra;
            end
         end
         s_reg: begin
            load_regfile = 1'b1;
            load_pc      = 1'b1;
            alumux2_sel  = alumux::rs2_out;
            aluop        = alu_ops'(funct3);
            if (funct3 == f3_slt || funct3 == f3_sltu) begin
               cmpop          = (funct3 == f3_slt) ? blt : bltu;
               regfilemux_sel = regfilemux::br_en;
            end else if (funct3 == f3_add && funct7) begin
               aluop = alu_sub;
            end else if (funct3 == f3_sr && funct7) begin
               aluop = alu_sra;
            end
         end
         s_lui: begin
            load_regfile   = 1'b1;
            load_pc        = 1'b1;
            regfilemux_sel = regfilemux::u_imm;
         end
         s_auipc: begin
            load_regfile = 1'b1;
            load_pc      = 1'b1;
            alumux1_sel  = alumux::pc_out;
            alumux2_sel  = alumux::u_imm;
         end
         s_br: begin
            load_pc     = 1'b1;
            cmpop       = branch_funct3_t'(funct3);
            alumux1_sel = alumux::pc_out;
            alumux2_sel = alumux::b_imm;
            pcmux_sel   = br_en ? pcmux::alu_out : pcmux::pc_plus4;
         end
         s_jal: begin
            load_pc        = 1'b1;
            load_regfile   = 1'b1;
            alumux1_sel    = alumux::pc_out;
            alumux2_sel    = alumux::j_imm;
            pcmux_sel      = pcmux::alu_out;
            regfilemux_sel = regfilemux::pc_plus4;
         end
         s_jalr: begin
            load_pc        = 1'b1;
            load_regfile   = 1'b1;
            pcmux_sel      = pcmux::alu_mod2;
            regfilemux_sel = regfilemux::pc_plus4;
         end
         s_calc_addr: begin
            marmux_sel = 1'b1;
            load_mar   = 1'b1;
            if (opcode == op_store) begin
               alumux2_sel   = alumux::s_imm;
               load_data_out = 1'b1;
            end
         end
         s_ld1: begin
            mem_read = 1'b1;
            load_mdr = 1'b1;
         end
         s_ld2: begin
            load_regfile = 1'b1;
            load_pc      = 1'b1;
            case (funct3)
               f3_lb:   regfilemux_sel = regfilemux::lb;
               f3_lh:   regfilemux_sel = regfilemux::lh;
               f3_lbu:  regfilemux_sel = regfilemux::lbu;
               f3_lhu:  regfilemux_sel = regfilemux::lhu;
               default: regfilemux_sel = regfilemux::lw;
            endcase
         end
         s_st1: begin
            mem_write       = 1'b1;
            mem_byte_enable = store_mask(funct3, addr_lo);
         end
         s_st2: load_pc = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      next_state = s_fetch1;
      case (state)
         s_fetch1:    next_state = s_fetch2;
         s_fetch2:    next_state = mem_resp ? s_fetch3 : s_fetch2;
         s_fetch3:    next_state = s_decode;
         s_decode: begin
            case (opcode)
               op_imm:   next_state = s_imm;
               op_reg:   next_state = s_reg;
               op_lui:   next_state = s_lui;
               op_auipc: next_state = s_auipc;
               op_br:    next_state = s_br;
               op_jal:   next_state = s_jal;
               op_jalr:  next_state = s_jalr;
               op_load,
               op_store: next_state = s_calc_addr;
               default:  next_state = s_fetch1;
            endcase
         end
         s_calc_addr: next_state = (opcode == op_store) ? s_st1 : s_ld1;
         s_ld1:       next_state = mem_resp ? s_ld2 : s_ld1;
         s_st1:       next_state = mem_resp ? s_st2 : s_st1;
         default:     next_state = s_fetch1;
      endcase
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction phase model, negedge compare of every output each cycle.
module tb_multicycle_control;
   import rv32i_types::*;

   logic                        clk = 1'b0;
   logic                        rst;
   logic [6:0]                  opcode;
   logic [2:0]                  funct3;
   logic                        funct7;
   logic                        br_en;
   logic [1:0]                  addr_lo;
   logic                        mem_resp;
   logic                        load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out;
   pcmux::pcmux_sel_t           pcmux_sel;
   alumux::alumux1_sel_t        alumux1_sel;
   alumux::alumux2_sel_t        alumux2_sel;
   regfilemux::regfilemux_sel_t regfilemux_sel;
   cmpmux::cmpmux_sel_t         cmpmux_sel;
   logic                        marmux_sel;
   alu_ops                      aluop;
   branch_funct3_t              cmpop;
   logic                        mem_read, mem_write;
   logic [3:0]                  mem_byte_enable;

   multicycle_control dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
      .br_en(br_en), .addr_lo(addr_lo), .mem_resp(mem_resp),
      .load_pc(load_pc), .load_ir(load_ir), .load_regfile(load_regfile),
      .load_mar(load_mar), .load_mdr(load_mdr), .load_data_out(load_data_out),
      .pcmux_sel(pcmux_sel), .alumux1_sel(alumux1_sel), .alumux2_sel(alumux2_sel),
      .regfilemux_sel(regfilemux_sel), .cmpmux_sel(cmpmux_sel), .marmux_sel(marmux_sel),
      .aluop(aluop), .cmpop(cmpop), .mem_read(mem_read), .mem_write(mem_write),
      .mem_byte_enable(mem_byte_enable)
   );

   always #5 clk = ~clk;

   // loads field order: {pc, ir, regfile, mar, mdr, data_out}
   typedef struct packed {
      logic [5:0] loads;
      logic [1:0] pcm;
      logic       am1;
      logic [2:0] am2;
      logic [3:0] rfm;
      logic       cm;
      logic       mm;
      logic [2:0] aop;
      logic [2:0] cop;
      logic       rd;
      logic       wr;
      logic [3:0] mbe;
   } vec_t;

   localparam int L_PC = 5, L_IR = 4, L_RF = 3, L_MAR = 2, L_MDR = 1, L_DO = 0;
   localparam int P_IADDR = 0, P_IWAIT = 1, P_IR = 2, P_DEC = 3, P_EXEC = 4,
                  P_DADDR = 5, P_DWAIT = 6, P_DONE = 7;

   localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                          OP_JALR = 7'b1100111, OP_BR = 7'b1100011, OP_LOAD = 7'b0000011,
                          OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_REG = 7'b0110011;

   vec_t dv;
   assign dv = {load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out,
                pcmux_sel, alumux1_sel, alumux2_sel, regfilemux_sel, cmpmux_sel, marmux_sel,
                aluop, cmpop, mem_read, mem_write, mem_byte_enable};

   int   checks = 0;
   int   failures = 0;
   int   ncyc;
   vec_t expq[$];
   int   phq[$];
   vec_t snap[8];

   // Expected outputs for one cycle of an instruction, from the instruction's meaning and its phase
   function automatic vec_t model(int ph, logic [6:0] op, logic [2:0] f3, logic f7,
                                  logic br, logic [1:0] alo);
      vec_t e;
      logic [3:0] m;
      logic is_st;
      e     = '0;
      e.mbe = 4'b1111;
      is_st = (op == OP_STORE);
      case (ph)
         P_IADDR: e.loads[L_MAR] = 1'b1;
         P_IWAIT: begin e.rd = 1'b1; e.loads[L_MDR] = 1'b1; end
         P_IR:    e.loads[L_IR] = 1'b1;
         P_DEC:   e.loads[L_PC] = !(op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BR,
                                               OP_LOAD, OP_STORE, OP_IMM, OP_REG});
         P_EXEC: begin
            e.loads[L_PC] = 1'b1;
            e.loads[L_RF] = (op != OP_BR);
            case (op)
               OP_IMM, OP_REG: begin
                  e.aop = f3;
                  if (op == OP_REG) e.am2 = alumux::rs2_out;
                  if (f3 == 3'b010 || f3 == 3'b011) begin
                     e.cop = (f3 == 3'b010) ? 3'b100 : 3'b110;
                     e.rfm = regfilemux::br_en;
                     if (op == OP_IMM) e.cm = cmpmux::i_imm;
                  end
                  if (f3 == 3'b101 && f7) e.aop = alu_sra;
                  if (op == OP_REG && f3 == 3'b000 && f7) e.aop = alu_sub;
               end
               OP_LUI:   e.rfm = regfilemux::u_imm;
               OP_AUIPC: begin e.am1 = alumux::pc_out; e.am2 = alumux::u_imm; end
               OP_BR: begin
                  e.cop = f3;
                  e.am1 = alumux::pc_out;
                  e.am2 = alumux::b_imm;
                  e.pcm = br ? pcmux::alu_out : pcmux::pc_plus4;
               end
               OP_JAL: begin
                  e.am1 = alumux::pc_out; e.am2 = alumux::j_imm;
                  e.pcm = pcmux::alu_out; e.rfm = regfilemux::pc_plus4;
               end
               default: begin
                  e.pcm = pcmux::alu_mod2; e.rfm = regfilemux::pc_plus4;
               end
            endcase
         end
         P_DADDR: begin
            e.mm = 1'b1;
            e.loads[L_MAR] = 1'b1;
            if (is_st) begin e.am2 = alumux::s_imm; e.loads[L_DO] = 1'b1; end
         end
         P_DWAIT: begin
            if (is_st) begin
               e.wr = 1'b1;
               m = (f3 == 3'b000) ? 4'b0001 : (f3 == 3'b001) ? 4'b0011 : 4'b1111;
               e.mbe = (f3 == 3'b010) ? m : m << alo;
            end else begin
               e.rd = 1'b1; e.loads[L_MDR] = 1'b1;
            end
         end
         default: begin
            e.loads[L_PC] = 1'b1;
            if (!is_st) begin
               e.loads[L_RF] = 1'b1;
               case (f3)
                  3'b000:  e.rfm = regfilemux::lb;
                  3'b001:  e.rfm = regfilemux::lh;
                  3'b100:  e.rfm = regfilemux::lbu;
                  3'b101:  e.rfm = regfilemux::lhu;
                  default: e.rfm = regfilemux::lw;
               endcase
            end
         end
      endcase
      return e;
   endfunction

   always @(negedge clk) begin
      vec_t e;
      int   ph;
      if (expq.size() > 0) begin
         e  = expq.pop_front();
         ph = phq.pop_front();
         snap[ph] = dv;
         checks++;
         if (dv !== e) begin
            failures++;
            $display("FAIL cycle phase=%0d t=%0t got=%h want=%h", ph, $time, dv, e);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   task automatic step(input int ph, input logic resp);
      mem_resp = resp;
      expq.push_back(model(ph, opcode, funct3, funct7, br_en, addr_lo));
      phq.push_back(ph);
      @(posedge clk);
      #1;
      mem_resp = 1'b0;
      ncyc++;
   endtask

   task automatic run(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic br,
                      input logic [1:0] alo, input int fw, input int mw, input logic stray);
      opcode = op; funct3 = f3; funct7 = f7; br_en = br; addr_lo = alo;
      ncyc = 0;
      step(P_IADDR, stray);
      for (int i = 0; i < fw; i++) step(P_IWAIT, 1'b0);
      step(P_IWAIT, 1'b1);
      step(P_IR, stray);
      step(P_DEC, stray);
      if (op == OP_LOAD || op == OP_STORE) begin
         step(P_DADDR, stray);
         for (int i = 0; i < mw; i++) step(P_DWAIT, 1'b0);
         step(P_DWAIT, 1'b1);
         step(P_DONE, stray);
      end else if (op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BR, OP_IMM, OP_REG}) begin
         step(P_EXEC, stray);
      end
   endtask

   initial begin
      rst = 1'b1; opcode = '0; funct3 = '0; funct7 = 1'b0; br_en = 1'b0;
      addr_lo = '0; mem_resp = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_load_mar", load_mar, 1);
      chk("rst_mem_read", mem_read, 0);
      chk("rst_mbe", mem_byte_enable, 4'hf);
      rst = 1'b0;

      run(OP_IMM, 3'b000, 1'b0, 1'b0, 2'd0, 2, 0, 1'b0);          // ADDI x1,x0,5
      chk("addi_cycles", ncyc, 7);
      chk("addi_exec_rf_pc", {snap[P_EXEC].loads[L_RF], snap[P_EXEC].loads[L_PC]}, 2'b11);

      run(OP_BR, 3'b000, 1'b0, 1'b1, 2'd0, 0, 0, 1'b1);
      chk("beq_taken_pcmux", snap[P_EXEC].pcm, pcmux::alu_out);
      chk("beq_taken_am2", snap[P_EXEC].am2, alumux::b_imm);
      run(OP_BR, 3'b000, 1'b0, 1'b0, 2'd0, 1, 0, 1'b0);
      chk("beq_nt_pcmux", snap[P_EXEC].pcm, pcmux::pc_plus4);
      run(OP_BR, 3'b101, 1'b0, 1'b1, 2'd0, 0, 0, 1'b0);            // BGE

      run(OP_STORE, 3'b000, 1'b0, 1'b0, 2'd2, 0, 1, 1'b1);
      chk("sb_mask", snap[P_DWAIT].mbe, 4'b0100);
      run(OP_STORE, 3'b001, 1'b0, 1'b0, 2'd2, 0, 0, 1'b0);
      chk("sh_mask", snap[P_DWAIT].mbe, 4'b1100);
      run(OP_STORE, 3'b010, 1'b0, 1'b0, 2'd1, 1, 2, 1'b1);
      chk("sw_mask", snap[P_DWAIT].mbe, 4'b1111);
      run(OP_STORE, 3'b000, 1'b0, 1'b0, 2'd3, 0, 0, 1'b0);

      run(OP_LOAD, 3'b101, 1'b0, 1'b0, 2'd0, 0, 2, 1'b1);
      chk("lhu_rfm", snap[P_DONE].rfm, regfilemux::lhu);
      run(OP_LOAD, 3'b000, 1'b0, 1'b0, 2'd0, 0, 0, 1'b0);
      run(OP_LOAD, 3'b010, 1'b0, 1'b0, 2'd0, 1, 1, 1'b0);

      run(OP_REG, 3'b000, 1'b1, 1'b0, 2'd0, 0, 0, 1'b1);
      chk("sub_aluop", snap[P_EXEC].aop, alu_sub);
      run(OP_IMM, 3'b101, 1'b1, 1'b0, 2'd0, 0, 0, 1'b0);
      chk("srai_aluop", snap[P_EXEC].aop, alu_sra);
      run(OP_REG, 3'b101, 1'b0, 1'b0, 2'd0, 0, 0, 1'b0);           // SRL
      run(OP_REG, 3'b011, 1'b0, 1'b0, 2'd0, 0, 0, 1'b0);           // SLTU
      run(OP_IMM, 3'b010, 1'b0, 1'b0, 2'd0, 0, 0, 1'b1);           // SLTI
      chk("slti_cmpmux", snap[P_EXEC].cm, cmpmux::i_imm);
      run(OP_LUI, 3'b000, 1'b0, 1'b0, 2'd0, 0, 0, 1'b0);
      run(OP_AUIPC, 3'b000, 1'b0, 1'b0, 2'd0, 1, 0, 1'b0);
      run(OP_JAL, 3'b000, 1'b0, 1'b0, 2'd0, 0, 0, 1'b1);
      run(OP_JALR, 3'b000, 1'b0, 1'b0, 2'd0, 0, 0, 1'b0);
      chk("jalr_pcmux", snap[P_EXEC].pcm, pcmux::alu_mod2);

      run(7'b0000000, 3'b000, 1'b0, 1'b0, 2'd0, 0, 0, 1'b1);
      chk("badop_decode_loads", snap[P_DEC].loads, 6'b100000);
      chk("badop_decode_strobes", {snap[P_DEC].rd, snap[P_DEC].wr}, 2'b00);

      // Reset in the middle of a load wait
      opcode = OP_LOAD; funct3 = 3'b010; funct7 = 1'b0; br_en = 1'b0; addr_lo = 2'd0;
      step(P_IADDR, 1'b0);
      step(P_IWAIT, 1'b1);
      step(P_IR, 1'b0);
      step(P_DEC, 1'b0);
      step(P_DADDR, 1'b0);
      #1;
      chk("ld1_read_before_rst", mem_read, 1);
      rst = 1'b1;
      #1;
      chk("ld1_read_in_rst", mem_read, 0);
      chk("ld1_mar_in_rst", load_mar, 1);
      expq.push_back(model(P_IADDR, opcode, funct3, funct7, br_en, addr_lo));
      phq.push_back(P_IADDR);
      @(posedge clk);
      #1;
      expq.push_back(model(P_IADDR, opcode, funct3, funct7, br_en, addr_lo));
      phq.push_back(P_IADDR);
      @(posedge clk);
      #1;
      rst = 1'b0;
      run(OP_IMM, 3'b111, 1'b0, 1'b0, 2'd0, 0, 0, 1'b0);           // ANDI after reset

      @(posedge clk);
      #1;
      chk("queue_drained", expq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
